div_mc_unit: RTL

Multi-cycle wrapper for the execute-stage divider datapath.
- Upstream side: captures operands and control from issue, holds them stable for DIV_LAT cycles so the combinational divider path can be constrained as a multicycle path.
- Downstream side: registers the divider output and presents it to writeback with a valid/ready handshake, stalling the pipeline while busy.
- Divide-by-zero and signed overflow are resolved locally with architecturally fixed values.

---
 rtl/div_mc_unit_pkg.sv | 28 ++
 rtl/div_mc_unit_div.sv | 36 +++
 rtl/div_mc_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/div_mc_unit_pkg.sv
// Shared constants and FSM encoding for the multi-cycle divide wrapper.
package div_mc_unit_pkg;

  localparam logic [3:0]  DIV_TYPE  = 4'd2;

  localparam logic [4:0]  DIV_W     = 5'd0;
  localparam logic [4:0]  MOD_W     = 5'd1;
  localparam logic [4:0]  DIV_WU    = 5'd2;
  localparam logic [4:0]  MOD_WU    = 5'd3;

  localparam logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic sub_is_signed(input logic [4:0] sub);
    return (sub == DIV_W) || (sub == MOD_W);
  endfunction

  function automatic logic sub_is_rem(input logic [4:0] sub);
    return (sub == MOD_W) || (sub == MOD_WU);
  endfunction

endpackage

// File: rtl/div_mc_unit_div.sv
// Combinational 32-bit divider; signed ops are done on magnitudes so the
// INT_MIN / -1 case never reaches a native signed divide.
module div_mc_unit_div
  import div_mc_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sub,
  output logic [31:0] result
);

  logic        is_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    is_signed = sub_is_signed(sub);
    neg_a     = is_signed && a[31];
    neg_b     = is_signed && b[31];
    mag_a     = neg_a ? (32'd0 - a) : a;
    mag_b     = neg_b ? (32'd0 - b) : b;
    uq        = mag_a / mag_b;
    ur        = mag_a % mag_b;
    // Quotient takes the xor of signs; remainder follows the dividend.
    if (sub_is_rem(sub)) begin
      result = neg_a ? (32'd0 - ur) : ur;
    end else begin
      result = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    end
  end

endmodule

// File: rtl/div_mc_unit.sv
// Multi-cycle wrapper: holds latched operands for DIV_LAT cycles, then
// presents the registered result to writeback with valid/ready.
module div_mc_unit
  import div_mc_unit_pkg::*;
#(
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rrj,
  input  logic [31:0] rrk,
  input  logic [31:0] ctr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        stall
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [4:0]         op_sub;
  logic [31:0]        result;
  logic [31:0]        div_res;

  logic               accept;
  logic               capture;
  logic               is_special;
  logic [31:0]        special_res;
  logic [3:0]         in_type;
  logic [4:0]         in_sub;
  logic               in_is_div;
  logic               in_rem;

  assign in_type = ctr[3:0];
  assign in_sub  = ctr[11:7];

  // Special cases are resolved from the raw issue inputs at accept time.
  always_comb begin
    in_is_div   = (in_type == DIV_TYPE) && (in_sub <= MOD_WU);
    in_rem      = sub_is_rem(in_sub);
    is_special  = 1'b0;
    special_res = '0;
    if (!in_is_div) begin
      is_special  = 1'b1;
      special_res = '0;
    end else if (rrk == '0) begin
      is_special  = 1'b1;
      special_res = in_rem ? rrj : DIVZERO_Q;
    end else if (sub_is_signed(in_sub) && (rrj == INT_MIN) && (rrk == '1)) begin
      is_special  = 1'b1;
      special_res = in_rem ? 32'd0 : INT_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept   = 1'b1;
          state_nx = is_special ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          capture  = !flush;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= '0;
      result <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      if (accept) begin
        op_a   <= rrj;
        op_b   <= rrk;
        op_sub <= in_sub;
        cnt    <= is_special ? '0 : CNT_W'(DIV_LAT - 1);
        if (is_special) begin
          result <= special_res;
        end
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        result <= div_res;
      end
    end
  end

  div_mc_unit_div u_div (
    .a      (op_a),
    .b      (op_b),
    .sub    (op_sub),
    .result (div_res)
  );

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign stall      = (state != IDLE);
  assign out_result = result;

endmodule
